// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   - state_e   : per-slot phase (BLANK dead time, SHOW digit lit)
//   - SEG_OFF   : active-high "all segments off" pattern
//   - SEG_TABLE : active-high {g,f,e,d,c,b,a} patterns for nibbles 0-F
//   - seg_decode: nibble -> segments, codes 10-15 blank when hex_mode=0
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble,
                                            input logic       hex_mode);
    logic [6:0] seg;
    if (!hex_mode && (nibble > 4'd9)) begin
      seg = SEG_OFF;
    end else begin
      seg = SEG_TABLE[nibble];
    end
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational nibble to seven-segment decoder (active-high segments).
//   nibble_i : 4-bit digit value
//   seg_o    : segments {g,f,e,d,c,b,a}, bit0 = a
// HEX_MODE=1 decodes 0-F; HEX_MODE=0 decodes 0-9 and blanks 10-15.
module seven_seg_decode
  import seven_seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i, (HEX_MODE != 0));

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment display driver.
//   clk, rst_n  : clock, asynchronous active-low reset
//   value       : packed nibbles, digit 0 = value[3:0]
//   dp_in       : decimal point request per digit
//   digit_en    : per-digit enable (0 blanks seg/dp, anode still scans)
//   load        : capture value/dp_in/digit_en/lz_blank into pending buffer
//   lz_blank    : leading-zero suppression, sampled with load
//   seg, dp     : segment and decimal point pins (polarity by SEG_ACTIVE_LOW)
//   an          : digit select pins (polarity by AN_ACTIVE_LOW)
//   frame_done  : pulse on the last lit cycle of the highest digit
// Each slot is BLANK_CYCLES dead cycles followed by SCAN_DIV lit cycles.
// All pins are registered from next-state values so they switch on the
// same edge as the phase change.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_RANGE = (SCAN_DIV > BLANK_CYCLES) ?
                             ((SCAN_DIV > 2) ? SCAN_DIV : 2) :
                             ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW = $clog2(CNT_RANGE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_PIN = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_PIN  = (SEG_ACTIVE_LOW != 0);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    frame_start_s;

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic                    pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;

  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic                    lz_chain_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic [3:0]              nibble_s;
  logic [6:0]              dec_seg_s;
  logic [6:0]              seg_raw_s;
  logic                    dp_raw_s;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  // Slot sequencer: BLANK/SHOW phase, digit index and phase cycle counter.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q + CW'(1);
    frame_start_s = 1'b0;
    case (state_q)
      BLANK: begin
        if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d         = '0;
          state_d       = (BLANK_CYCLES == 0) ? SHOW : BLANK;
          frame_start_s = (idx_q == IDX_LAST);
          idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d = BLANK;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffer: pending follows load; active only changes at frame start,
  // taking load data directly when load lands on that edge.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    pend_lz_d  = pend_lz_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    act_lz_d   = act_lz_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_en_d  = digit_en;
      pend_lz_d  = lz_blank;
    end else begin
      pend_val_d = pend_val_q;
    end
    if (frame_start_s) begin
      act_val_d = load ? value    : pend_val_q;
      act_dp_d  = load ? dp_in    : pend_dp_q;
      act_en_d  = load ? digit_en : pend_en_q;
      act_lz_d  = load ? lz_blank : pend_lz_q;
    end else begin
      act_val_d = act_val_q;
    end
  end

  // Leading-zero mask, scanned from the top digit down. A disabled digit does
  // not break the run of suppressed leading digits; digit 0 is never masked.
  always_comb begin
    lz_mask_s  = '0;
    lz_chain_s = act_lz_d;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_chain_s && (act_val_d[4*i +: 4] == 4'h0)) begin
        lz_mask_s[i] = 1'b1;
      end else begin
        lz_mask_s[i] = 1'b0;
      end
      if ((act_val_d[4*i +: 4] != 4'h0) && act_en_d[i]) begin
        lz_chain_s = 1'b0;
      end else begin
        lz_chain_s = lz_chain_s;
      end
    end
  end

  assign nibble_s = act_val_d[{idx_d, 2'b00} +: 4];

  seven_seg_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .nibble_i(nibble_s),
    .seg_o   (dec_seg_s)
  );

  // Pin values for the upcoming cycle, derived from next state and buffer.
  always_comb begin
    onehot_s  = '0;
    seg_raw_s = SEG_OFF;
    dp_raw_s  = 1'b0;
    an_d      = AN_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (idx_d == IW'(i));
    end
    if (state_d == SHOW) begin
      an_d = (AN_ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
      if (act_en_d[idx_d] && !lz_mask_s[idx_d]) begin
        seg_raw_s = dec_seg_s;
        dp_raw_s  = act_dp_d[idx_d];
      end else begin
        seg_raw_s = SEG_OFF;
        dp_raw_s  = 1'b0;
      end
    end else begin
      an_d = AN_OFF;
    end
    seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_raw_s : seg_raw_s;
    dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_raw_s : dp_raw_s;
    frame_done_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
  end

  // State, buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_lz_q    <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      act_lz_q     <= 1'b0;
      seg_q        <= SEG_PIN;
      dp_q         <= DP_PIN;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_lz_q    <= pend_lz_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      act_lz_q     <= act_lz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, SCAN_DIV=4,
// BLANK_CYCLES=1). A hex-mode and a decimal-mode instance share inputs and
// run in lockstep. Expected digit images are queued when a load is driven and
// popped as each digit's lit phase appears on the pins.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          load;
  logic          lz_blank;

  logic [6:0]    seg_h, seg_d;
  logic          dp_h, dp_d;
  logic [3:0]    an_h, an_d;
  logic          fd_h, fd_d;

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .lz_blank(lz_blank),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut_dec (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .load(load), .lz_blank(lz_blank),
    .seg(seg_d), .dp(dp_d), .an(an_d), .frame_done(fd_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic       dec;
  } exp_t;

  typedef struct {
    logic [15:0] v_value;
    logic [3:0]  v_dp;
    logic [3:0]  v_en;
    logic        v_lz;
    logic        v_dec;
    int          load_cyc;
    logic [27:0] exp_seg;   // {d3,d2,d1,d0}, 7 bits each
    logic [3:0]  exp_dp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  vec_t idle_v;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      e.seg = v.exp_seg[d*7 +: 7];
      e.dp  = v.exp_dp[d];
      e.dec = v.v_dec;
      sb_q.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    e.seg = 7'h00;
    e.dp  = 1'b0;
    e.dec = 1'b0;
    for (int d = 0; d < ND; d++) sb_q.push_back(e);
  endtask

  // Observe one 20-cycle frame starting right after a frame boundary.
  // Optionally loads vector v at frame cycle load_cyc (0..19).
  task automatic observe_frame(input int load_cyc, input vec_t v);
    exp_t       e;
    int         d;
    int         ph;
    logic [3:0] an_exp;
    e.seg = 7'h00;
    e.dp  = 1'b0;
    e.dec = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      d  = c / 5;
      ph = c % 5;
      if (ph == 0) begin
        chk($sformatf("dead_an c%0d", c), 7'(an_h), 7'h0F);
        chk($sformatf("dead_seg c%0d", c), seg_h, 7'h00);
        chk($sformatf("dead_dp c%0d", c), 7'(dp_h), 7'h00);
      end else begin
        if (ph == 1) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty c%0d: got no entry, expected one", c);
          end else begin
            e = sb_q.pop_front();
          end
        end
        an_exp = ~(4'b0001 << d);
        chk($sformatf("an d%0d c%0d", d, c), 7'(e.dec ? an_d : an_h), 7'(an_exp));
        chk($sformatf("seg d%0d c%0d", d, c), e.dec ? seg_d : seg_h, e.seg);
        chk($sformatf("dp d%0d c%0d", d, c), 7'(e.dec ? dp_d : dp_h), 7'(e.dp));
      end
      chk($sformatf("frame_done c%0d", c), 7'(fd_h), 7'(c == 19));
      if (c == load_cyc) begin
        value    = v.v_value;
        dp_in    = v.v_dp;
        digit_en = v.v_en;
        lz_blank = v.v_lz;
        load     = 1'b1;
        push_vec(v);
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{v_value:16'h12AF, v_dp:4'b0000, v_en:4'hF, v_lz:1'b0, v_dec:1'b0, load_cyc:7,
                exp_seg:{7'h06, 7'h5B, 7'h77, 7'h71}, exp_dp:4'b0000};
    vecs[1] = '{v_value:16'h9A05, v_dp:4'b0000, v_en:4'hF, v_lz:1'b0, v_dec:1'b1, load_cyc:19,
                exp_seg:{7'h6F, 7'h00, 7'h3F, 7'h6D}, exp_dp:4'b0000};
    vecs[2] = '{v_value:16'h0040, v_dp:4'b1000, v_en:4'hF, v_lz:1'b1, v_dec:1'b0, load_cyc:2,
                exp_seg:{7'h00, 7'h00, 7'h66, 7'h3F}, exp_dp:4'b0000};
    vecs[3] = '{v_value:16'h1111, v_dp:4'b0000, v_en:4'hF, v_lz:1'b0, v_dec:1'b0, load_cyc:12,
                exp_seg:{7'h06, 7'h06, 7'h06, 7'h06}, exp_dp:4'b0000};
    vecs[4] = '{v_value:16'h5678, v_dp:4'b0101, v_en:4'b1011, v_lz:1'b0, v_dec:1'b0, load_cyc:0,
                exp_seg:{7'h6D, 7'h00, 7'h07, 7'h7F}, exp_dp:4'b0001};
    vecs[5] = '{v_value:16'h0000, v_dp:4'b0001, v_en:4'hF, v_lz:1'b1, v_dec:1'b0, load_cyc:16,
                exp_seg:{7'h00, 7'h00, 7'h00, 7'h3F}, exp_dp:4'b0001};
    vecs[6] = '{v_value:16'h3C0E, v_dp:4'b0010, v_en:4'hF, v_lz:1'b1, v_dec:1'b0, load_cyc:19,
                exp_seg:{7'h4F, 7'h39, 7'h3F, 7'h79}, exp_dp:4'b0010};
    vecs[7] = '{v_value:16'h00B0, v_dp:4'b0000, v_en:4'hF, v_lz:1'b1, v_dec:1'b1, load_cyc:9,
                exp_seg:{7'h00, 7'h00, 7'h00, 7'h3F}, exp_dp:4'b0000};
    vecs[8] = '{v_value:16'h8888, v_dp:4'b1111, v_en:4'hF, v_lz:1'b1, v_dec:1'b0, load_cyc:5,
                exp_seg:{7'h7F, 7'h7F, 7'h7F, 7'h7F}, exp_dp:4'b1111};
    idle_v  = vecs[0];

    rst_n    = 1'b1;
    value    = 16'hFFFF;
    dp_in    = 4'hF;
    digit_en = 4'hF;
    load     = 1'b0;
    lz_blank = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_an", 7'(an_h), 7'h0F);
    chk("rst_seg", seg_h, 7'h00);
    chk("rst_dp", 7'(dp_h), 7'h00);
    chk("rst_fd", 7'(fd_h), 7'h00);

    // Release just after an edge; the first frame shows the zeroed buffer.
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_zero();

    for (int i = 0; i < 9; i++) begin
      observe_frame(vecs[i].load_cyc, vecs[i]);
    end
    observe_frame(-1, idle_v);

    // Asynchronous reset in the middle of digit 2's lit phase.
    repeat (12) @(negedge clk);
    chk("pre_rst_an", 7'(an_h), 7'h0B);
    chk("pre_rst_seg", seg_h, 7'h7F);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 7'(an_h), 7'h0F);
    chk("async_rst_seg", seg_h, 7'h00);
    chk("async_rst_dp", 7'(dp_h), 7'h00);
    chk("async_rst_fd", 7'(fd_h), 7'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
    push_zero();
    push_zero();
    observe_frame(-1, idle_v);
    observe_frame(-1, idle_v);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display, the parametrised successor of the single-digit combinational decoder.
- Holds a double-buffered packed nibble value and scans one digit at a time at a programmable rate.
- Inserts anti-ghosting dead time between digits.
- Supports hex or decimal decode, leading-zero blanking, per-digit enables, decimal points and output polarity.
- Sits between the datapath (counters, status values) and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..16).
- SCAN_DIV, 1000: clock cycles each digit is lit per slot (>=1).
- BLANK_CYCLES, 2: dead-time cycles per slot with all anodes off (>=0).
- HEX_MODE, 1: 1 = decode 0-F; 0 = decode 0-9, codes 10-15 blank.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1: 1 means an[i]=0 selects digit i.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  packed nibbles; digit 0 = value[3:0] (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit (seg and dp off, anode still cycles).
- load  in  1  capture value/dp_in/digit_en into pending buffer.
- lz_blank  in  1  leading-zero suppression enable (sampled with load).
- seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a.
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  digit select (one-hot when lit, none during dead time).
- frame_done  out  1  one-cycle pulse on last cycle of digit NUM_DIGITS-1 lit phase.

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low on rst_n.
- Reset values: state BLANK, digit index 0, cycle counter 0, pending and active buffers all 0 (lz_blank 0), frame_done 0. an = all inactive, seg = all off, dp off, at the polarity set by the parameters.
- FSM per slot:
  - BLANK: BLANK_CYCLES cycles, an inactive, seg/dp off. If BLANK_CYCLES=0, BLANK is skipped and the slot is SHOW only.
  - SHOW: SCAN_DIV cycles, an[idx] active, seg/dp from decode.
  - After SHOW, idx increments, wrapping NUM_DIGITS-1 -> 0; slot length = BLANK_CYCLES+SCAN_DIV cycles.
- Counter width: $clog2(max(SCAN_DIV,BLANK_CYCLES,2)). The counter resets to 0 at each phase change.
- Outputs are registered: an, seg and dp change on the same edge as the phase change, with no glitch between digits.
- Buffering:
  - load=1 writes the pending buffer.
  - The active buffer copies pending on the edge that starts a frame (entry to digit 0 slot), so a frame never mixes old and new values.
  - If load coincides with the frame-start edge, the active buffer takes the load data directly.
  - A load in any other cycle takes effect at the next frame start.
- Decode table (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71. In decimal mode 10-15 decode to 00.
- Leading-zero blanking (active lz_blank=1): a digit whose nibble is 0 is blanked if all higher digits are 0 or blanked. Digit 0 is never blanked by this rule, and its dp is still shown. The dp of a blanked digit is also suppressed.
- digit_en=0 takes priority over decode and dp.
- frame_done pulses exactly once per frame.
- Reset asserted mid-slot returns all outputs to reset values immediately. Scanning restarts at BLANK of digit 0 after deassertion.
- NUM_DIGITS=1: an stays on digit 0 and toggles only for dead time.

Decomposition:
- Package seven_seg_pkg:
  - 16-entry segment constant array (active-high).
  - SEG_OFF constant.
  - FSM state enum {BLANK, SHOW}.
  - Function seg_decode(nibble, hex_mode).
- Sub-module seven_seg_decode: combinational nibble -> 7-bit segments, parameter HEX_MODE. One instance, driven by the muxed active nibble.

Test Plan:
1. Params NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, default polarity. Reset, then load value=16'h12AF, all enables set -> digits light in order 0..3 with seg 71,77,5B,06 (inverted at pins only if SEG_ACTIVE_LOW=1). an=1110,1101,1011,0111 for 4 cycles each, 1111 for 1 cycle between. frame_done every 20 cycles.
2. HEX_MODE=0, value=16'h9A05 -> digit 0 seg=6D, digit 1=3F, digit 2=00 (blank), digit 3=6F.
3. lz_blank=1, value=16'h0040, dp_in=4'b1000 -> digits 3 and 2 blank, including the dp of digit 3; digit 1=66, digit 0=3F; dp off everywhere.
4. Load 16'h1111 during digit 2 of a frame -> rest of the frame shows the old value; the next frame shows 06 on all digits. A load on the frame-start edge shows the new value in that same frame.
5. digit_en=4'b1011, dp_in=4'b0100 -> digit 2 slot has its anode active but seg=00 and dp=0.
6. Assert rst_n low during a SHOW of digit 2 -> an, seg and dp go to reset values within the same cycle, without waiting for a clock edge. After release, the first lit digit is 0 after BLANK_CYCLES cycles, and the value is 0 until the next load.
